// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared constants, loader state encoding and baud divisor helper
package boot_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA,
    ST_CHK,
    ST_RUN
  } load_state_e;

  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/boot_if.sv
// rtl/boot_if.sv - received-byte stream between the UART receiver and the loader
interface boot_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       frame_err;

  modport master (output tdata, output tvalid, output frame_err);
  modport slave  (input  tdata, input  tvalid, input  frame_err);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver: synchronizer, false-start rejection, stop-bit framing check
module uart_rx #(
  parameter int unsigned DIV = 10
) (
  input  logic   i_clk,
  input  logic   i_arst_n,
  input  logic   i_rx,
  boot_if.master rx_o
);

  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e        state_q;
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             ferr_q;

  // sync_q[1] is the synchronized line, sync_q[2] its previous value for edge detection
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= RX_IDLE;
      sync_q  <= 3'b111;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], i_rx};
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (sync_q[2] && !sync_q[1]) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (cnt_q == HALF) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= sync_q[1] ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == FULL) begin
            cnt_q   <= '0;
            shift_q <= {sync_q[1], shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == FULL) begin
            state_q <= RX_IDLE;
            if (sync_q[1]) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign rx_o.tdata     = data_q;
  assign rx_o.tvalid    = valid_q;
  assign rx_o.frame_err = ferr_q;

endmodule

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - framed UART image loader; writes words from address 0 and releases the CPU on a good checksum
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_rx,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_cpu_rst_n,
  output logic              o_busy,
  output logic              o_err
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  boot_if rx_if ();

  uart_rx #(.DIV(DIV)) u_rx (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_rx     (i_rx),
    .rx_o     (rx_if)
  );

  load_state_e       state_q;
  logic [7:0]        cnt_hi_q;
  logic [16:0]       words_left_q;
  logic [1:0]        byte_idx_q;
  logic [7:0]        sum_q;
  logic [23:0]       asm_q;
  logic [ADDR_W-1:0] addr_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              cpu_rst_n_q;
  logic              busy_q;
  logic              err_q;

  logic [16:0] count_w;
  logic        in_frame;
  assign count_w  = {1'b0, cnt_hi_q, rx_if.tdata};
  assign in_frame = (state_q != ST_IDLE) && (state_q != ST_RUN);

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q      <= ST_IDLE;
      cnt_hi_q     <= '0;
      words_left_q <= '0;
      byte_idx_q   <= '0;
      sum_q        <= '0;
      asm_q        <= '0;
      addr_q       <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rst_n_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (rx_if.frame_err && in_frame) begin
        err_q   <= 1'b1;
        busy_q  <= 1'b0;
        state_q <= ST_IDLE;
      end else if (rx_if.tvalid) begin
        case (state_q)
          ST_IDLE: begin
            if (rx_if.tdata == SYNC_BYTE) begin
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= ST_CNT_HI;
            end
          end
          ST_CNT_HI: begin
            cnt_hi_q <= rx_if.tdata;
            state_q  <= ST_CNT_LO;
          end
          ST_CNT_LO: begin
            sum_q <= '0;
            if (count_w > MAX_WORDS) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else if (count_w == '0) begin
              state_q <= ST_CHK;
            end else begin
              words_left_q <= count_w;
              addr_q       <= '0;
              byte_idx_q   <= '0;
              state_q      <= ST_DATA;
            end
          end
          ST_DATA: begin
            asm_q      <= {asm_q[15:0], rx_if.tdata};
            sum_q      <= sum_q + rx_if.tdata;
            byte_idx_q <= byte_idx_q + 1'b1;
            // Output address is a separate register so it holds between writes
            if (byte_idx_q == 2'd3) begin
              mem_we_q     <= 1'b1;
              mem_addr_q   <= addr_q;
              mem_wdata_q  <= {asm_q, rx_if.tdata};
              addr_q       <= addr_q + 1'b1;
              words_left_q <= words_left_q - 17'd1;
              if (words_left_q == 17'd1) state_q <= ST_CHK;
            end
          end
          ST_CHK: begin
            busy_q <= 1'b0;
            if (rx_if.tdata == sum_q) begin
              cpu_rst_n_q <= 1'b1;
              state_q     <= ST_RUN;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
          ST_RUN: begin
            if (rx_if.tdata == SYNC_BYTE) begin
              cpu_rst_n_q <= 1'b0;
              err_q       <= 1'b0;
              busy_q      <= 1'b1;
              state_q     <= ST_CNT_HI;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_cpu_rst_n = cpu_rst_n_q;
  assign o_busy      = busy_q;
  assign o_err       = err_q;

endmodule
